// File: rtl/pc_unit.sv
// Fetch program counter: sequential / redirect / call-return next-PC with circular RAS.
// Latency: pc_out follows a request on the next rising edge; pc_plus_inc and RAS flags are combinational.
// Backpressure: stall freezes every register; optional target alignment check under PC_ALIGN_CHECK_EN.
module pc_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    PC_INC       = 4,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  call,
  input  logic                  ret,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] pc_plus_inc,
  output logic                  ras_empty,
  output logic                  ras_full,
  output logic                  ras_underflow,
  output logic                  misaligned
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]      top_q, top_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  uf_q, uf_d;
  logic                  mis_q, mis_d;
  logic                  ras_we;
  logic [PTR_W-1:0]      ras_waddr;
  logic                  align_bad;

`ifdef PC_ALIGN_CHECK_EN
  assign align_bad = |(redirect_target & DATA_WIDTH'(PC_INC - 1));
`else
  assign align_bad = 1'b0;
`endif

  assign pc_out        = pc_q;
  assign pc_plus_inc   = pc_q + DATA_WIDTH'(PC_INC);
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_underflow = uf_q;
  assign misaligned    = mis_q;

  always_comb begin
    pc_d      = pc_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    uf_d      = uf_q;
    mis_d     = 1'b0;
    ras_we    = 1'b0;
    ras_waddr = top_q;
    if (!stall) begin
      if (ret && !ras_empty) begin
        pc_d = ras_q[top_q];
        // call+ret swaps the top entry in place, so depth is unchanged
        if (call) begin
          ras_we = 1'b1;
        end else begin
          top_d = top_q - PTR_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else begin
        if (ret) uf_d = 1'b1;
        if (redirect_valid && !align_bad) begin
          pc_d = redirect_target;
          if (call) begin
            // a full stack overwrites its oldest entry as the pointer wraps
            ras_we    = 1'b1;
            ras_waddr = top_q + PTR_W'(1);
            top_d     = top_q + PTR_W'(1);
            if (!ras_full) cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          pc_d  = pc_plus_inc;
          mis_d = redirect_valid & align_bad;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc_q  <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
      uf_q  <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
      mis_q <= mis_d;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (ras_we) begin
      ras_q[ras_waddr] <= pc_plus_inc;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: vector table for the basic flow, hand sequences for RAS and reset corners.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        stall, redirect_valid, call, ret;
  logic [31:0] redirect_target;
  logic [31:0] pc_out, pc_plus_inc;
  logic        ras_empty, ras_full, ras_underflow, misaligned;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .call            (call),
    .ret             (ret),
    .pc_out          (pc_out),
    .pc_plus_inc     (pc_plus_inc),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .ras_underflow   (ras_underflow),
    .misaligned      (misaligned)
  );

  typedef struct {
    logic        st, rv, cl, rt;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        emp, full, uf;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(logic st, logic rv, logic cl, logic rt, logic [31:0] tgt,
                              logic [31:0] pc, logic emp, logic full, logic uf);
    vec_t v;
    v.st = st; v.rv = rv; v.cl = cl; v.rt = rt; v.tgt = tgt;
    v.pc = pc; v.emp = emp; v.full = full; v.uf = uf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rv, input logic cl, input logic rt,
                       input logic [31:0] tgt);
    stall = st; redirect_valid = rv; call = cl; ret = rt; redirect_target = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic [31:0] pc, input logic emp,
                           input logic full, input logic uf, input logic mis);
    chk({name, ".pc"}, pc_out, pc);
    chk({name, ".pc_plus_inc"}, pc_plus_inc, pc + 32'd4);
    chk({name, ".ras_empty"}, {31'd0, ras_empty}, {31'd0, emp});
    chk({name, ".ras_full"}, {31'd0, ras_full}, {31'd0, full});
    chk({name, ".ras_underflow"}, {31'd0, ras_underflow}, {31'd0, uf});
    chk({name, ".misaligned"}, {31'd0, misaligned}, {31'd0, mis});
  endtask

  initial begin
    logic [31:0] base;
    //                st rv cl rt target        pc             emp full uf
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,        32'h4,        1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 32'h0,        32'h8,        1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 32'h0,        32'hC,        1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 32'h0,        32'h10,       1, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 32'h40,       32'h10,       1, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 32'h40,       32'h10,       1, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0, 32'h40,       32'h40,       1, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0, 32'h20,       32'h20,       1, 0, 0);
    tbl[8]  = mk(0, 1, 1, 0, 32'h100,      32'h100,      0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 32'h0,        32'h104,      0, 0, 0);
    tbl[10] = mk(0, 1, 1, 0, 32'h200,      32'h200,      0, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 32'h0,        32'h108,      0, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 32'h0,        32'h24,       1, 0, 0);
    tbl[13] = mk(0, 1, 0, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0);
    tbl[15] = mk(0, 0, 1, 0, 32'h0,        32'h4,        1, 0, 0);
    tbl[16] = mk(1, 0, 0, 1, 32'h0,        32'h4,        1, 0, 0);

    drive(0, 0, 0, 0, 32'h0);
    arst_n = 1'b0;
    #12;
    chk_state("reset", 32'h0, 1, 0, 0, 0);
    arst_n = 1'b1;
    #2;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].st, tbl[i].rv, tbl[i].cl, tbl[i].rt, tbl[i].tgt);
      step();
      chk_state($sformatf("vec%0d", i), tbl[i].pc, tbl[i].emp, tbl[i].full, tbl[i].uf, 1'b0);
    end

    // Five nested calls into a four-deep stack, then five returns.
    drive(0, 1, 0, 0, 32'h1000);
    step();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, 1, 0, 32'h1000 * (k + 1));
      step();
      chk_state($sformatf("nest_call%0d", k), 32'h1000 * (k + 1), 0, k >= 4, 0, 0);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 32'h0);
      step();
      chk_state($sformatf("nest_ret%0d", k), 32'h1000 * (5 - k) + 32'h4, k == 3, 0, 0, 0);
    end
    drive(0, 0, 0, 1, 32'h0);
    step();
    chk_state("underflow_ret", 32'h2008, 1, 0, 1, 0);

    // Simultaneous call and ret swap the top entry.
    drive(0, 1, 0, 0, 32'h2FC);
    step();
    drive(0, 1, 1, 0, 32'h50);
    step();
    chk_state("setup_top300", 32'h50, 0, 0, 1, 0);
    drive(0, 1, 1, 1, 32'h999);
    step();
    chk_state("call_ret", 32'h300, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 32'h0);
    step();
    chk_state("ret_swapped", 32'h54, 1, 0, 1, 0);

    // Misaligned redirect with call.
    drive(0, 1, 0, 0, 32'h60);
    step();
    drive(0, 1, 1, 0, 32'h42);
    step();
`ifdef PC_ALIGN_CHECK_EN
    chk_state("misalign", 32'h64, 1, 0, 1, 1);
    drive(0, 0, 0, 0, 32'h0);
    step();
    chk_state("misalign_after", 32'h68, 1, 0, 1, 0);
`else
    chk_state("unaligned_load", 32'h42, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 32'h0);
    step();
    chk_state("unaligned_after", 32'h46, 0, 0, 1, 0);
`endif

    // Asynchronous reset mid-stream, away from any clock edge.
    drive(0, 1, 1, 0, 32'h800);
    step();
    #2;
    arst_n = 1'b0;
    #1;
    chk_state("async_reset", 32'h0, 1, 0, 0, 0);
    base = 32'h0;
    @(negedge clk);
    arst_n = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    step();
    chk_state("post_reset", base + 32'h4, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
